// File: rtl/mac_op_driver.sv
// mac_op_driver: drives one systolic-array MAC unit from an FP16 operand stream and returns
// single or chained dot-product results. Define MAC_OP_DRIVER_PERF_EN to build the perf counters.
module mac_op_driver #(
  parameter int MAC_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_value,
  input  logic [15:0]      op_weight,
  input  logic [15:0]      op_acc,
  input  logic             op_first,
  input  logic             op_last,
  output logic             mac_start,
  output logic [15:0]      mac_in_value,
  output logic [15:0]      mac_weight,
  output logic [15:0]      mac_in_accumulate,
  input  logic [15:0]      mac_out_accumulate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             busy,
  output logic [CNT_W-1:0] perf_ops,
  output logic [CNT_W-1:0] perf_stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  localparam logic [3:0] CntLoad = 4'(MAC_LATENCY - 1);

  state_t      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic [15:0] weight_q, weight_d;
  logic [15:0] accIn_q, accIn_d;
  logic [15:0] accum_q, accum_d;
  logic [15:0] resData_q, resData_d;
  logic        last_q, last_d;
  logic        chainActive_q, chainActive_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      value_q       <= '0;
      weight_q      <= '0;
      accIn_q       <= '0;
      accum_q       <= '0;
      resData_q     <= '0;
      last_q        <= 1'b0;
      chainActive_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      weight_q      <= weight_d;
      accIn_q       <= accIn_d;
      accum_q       <= accum_d;
      resData_q     <= resData_d;
      last_q        <= last_d;
      chainActive_q <= chainActive_d;
      cnt_q         <= cnt_d;
    end
  end

  // Operand registers only load on IDLE->ISSUE, so the MAC sees stable inputs while in flight.
  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    weight_d      = weight_q;
    accIn_d       = accIn_q;
    accum_d       = accum_q;
    resData_d     = resData_q;
    last_d        = last_q;
    chainActive_d = chainActive_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          value_d  = op_value;
          weight_d = op_weight;
          last_d   = op_last;
          accIn_d  = (op_first || !chainActive_q) ? op_acc : accum_q;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CntLoad;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          accum_d = mac_out_accumulate;
          if (last_q) begin
            resData_d     = mac_out_accumulate;
            chainActive_d = 1'b0;
            state_d       = OUT;
          end else begin
            chainActive_d = 1'b1;
            state_d       = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      OUT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign op_ready          = (state_q == IDLE);
  assign mac_start         = (state_q == ISSUE);
  assign res_valid         = (state_q == OUT);
  assign busy              = (state_q != IDLE);
  assign mac_in_value      = value_q;
  assign mac_weight        = weight_q;
  assign mac_in_accumulate = accIn_q;
  assign res_data          = resData_q;

`ifdef MAC_OP_DRIVER_PERF_EN
  logic [CNT_W-1:0] perfOps_q, perfStall_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      perfOps_q   <= '0;
      perfStall_q <= '0;
    end else begin
      if (state_q == WAIT && cnt_q == 4'd0) perfOps_q <= perfOps_q + CNT_W'(1);
      if (state_q == OUT && !res_ready) perfStall_q <= perfStall_q + CNT_W'(1);
    end
  end

  assign perf_ops   = perfOps_q;
  assign perf_stall = perfStall_q;
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mac_op_driver.sv
// tb_mac_op_driver: directed scoreboard bench for mac_op_driver with a behavioural MAC that
// returns hand-computed FP16 results exactly MAC_LATENCY cycles after each start pulse.
module tb_mac_op_driver;
  localparam int LAT = 3;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [15:0]   op_value = '0, op_weight = '0, op_acc = '0;
  logic          op_first = 1'b0, op_last = 1'b0;
  logic          mac_start;
  logic [15:0]   mac_in_value, mac_weight, mac_in_accumulate;
  logic [15:0]   mac_out_accumulate = 16'hDEAD;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [15:0]   res_data;
  logic          busy;
  logic [CW-1:0] perf_ops, perf_stall;

  mac_op_driver #(.MAC_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .nRST(nRST),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_value(op_value), .op_weight(op_weight), .op_acc(op_acc),
    .op_first(op_first), .op_last(op_last),
    .mac_start(mac_start), .mac_in_value(mac_in_value), .mac_weight(mac_weight),
    .mac_in_accumulate(mac_in_accumulate), .mac_out_accumulate(mac_out_accumulate),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .perf_ops(perf_ops), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int stallSeen = 0;

  logic [47:0] issueQ[$];
  logic [15:0] macQ[$];
  logic [15:0] resQ[$];

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  // Behavioural MAC: result appears in the cycle ISSUE+LAT, garbage otherwise.
  int          macCnt = 0;
  bit          macPend = 1'b0;
  logic [15:0] macRes = '0;

  always @(negedge clk) begin
    if (!nRST) begin
      macCnt = 0;
      macPend = 1'b0;
      mac_out_accumulate = 16'hDEAD;
    end else begin
      if (mac_start) begin
        macCnt = LAT;
        macPend = 1'b1;
        if (macQ.size() > 0) macRes = macQ.pop_front();
        else macRes = 16'hBAD0;
      end else if (macCnt > 0) begin
        macCnt--;
      end
      if (macPend && macCnt == 0) begin
        mac_out_accumulate = macRes;
        macPend = 1'b0;
      end else begin
        mac_out_accumulate = 16'hDEAD;
      end
    end
  end

  // Monitor: compares issued operands, operand stability and results against the queues.
  logic        prevStart = 1'b0;
  logic        inOut = 1'b0;
  logic [15:0] heldV = '0, heldW = '0, heldA = '0, curRes = '0;
  int          startCycle = 0;

  always @(negedge clk) begin
    if (!nRST) begin
      prevStart = 1'b0;
      inOut = 1'b0;
    end else begin
      if (mac_start) begin
        checkOutput("startPulseWidth", prevStart, 1'b0);
        checkOutput("readyInIssue", op_ready, 1'b0);
        if (issueQ.size() == 0) begin
          checkOutput("unexpectedIssue", 1'b1, 1'b0);
        end else begin
          logic [47:0] e;
          e = issueQ.pop_front();
          checkOutput("issueValue", mac_in_value, e[47:32]);
          checkOutput("issueWeight", mac_weight, e[31:16]);
          checkOutput("issueAcc", mac_in_accumulate, e[15:0]);
        end
        heldV = mac_in_value;
        heldW = mac_weight;
        heldA = mac_in_accumulate;
        startCycle = cycleCount;
      end else if (busy && !res_valid) begin
        checkOutput("waitValueHeld", mac_in_value, heldV);
        checkOutput("waitWeightHeld", mac_weight, heldW);
        checkOutput("waitAccHeld", mac_in_accumulate, heldA);
        checkOutput("readyInWait", op_ready, 1'b0);
      end
      if (res_valid) begin
        if (!inOut) begin
          if (resQ.size() == 0) begin
            checkOutput("unexpectedResult", 1'b1, 1'b0);
            curRes = res_data;
          end else begin
            curRes = resQ.pop_front();
            checkOutput("resData", res_data, curRes);
            checkOutput("resLatency", cycleCount - startCycle, LAT + 1);
          end
          inOut = 1'b1;
        end else begin
          checkOutput("resDataHeld", res_data, curRes);
        end
        checkOutput("readyInOut", op_ready, 1'b0);
        checkOutput("noStartInOut", mac_start, 1'b0);
        if (!res_ready) stallSeen++;
        else inOut = 1'b0;
      end
      prevStart = mac_start;
    end
  end

  task automatic applyStimulus(input logic [15:0] v, input logic [15:0] w, input logic [15:0] a,
                               input logic f, input logic l, input logic [15:0] expAcc,
                               input logic [15:0] macResult, input bit expectResult);
    int n;
    issueQ.push_back({v, w, expAcc});
    macQ.push_back(macResult);
    if (expectResult) resQ.push_back(macResult);
    op_value = v;
    op_weight = w;
    op_acc = a;
    op_first = f;
    op_last = l;
    op_valid = 1'b1;
    n = 0;
    while (!op_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) checkOutput("acceptTimeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while ((busy || resQ.size() != 0 || issueQ.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, "Done"}, n < 200, 1'b1);
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "OpReady"}, op_ready, 1'b1);
    checkOutput({name, "MacStart"}, mac_start, 1'b0);
    checkOutput({name, "MacValue"}, mac_in_value, 16'h0000);
    checkOutput({name, "MacWeight"}, mac_weight, 16'h0000);
    checkOutput({name, "MacAcc"}, mac_in_accumulate, 16'h0000);
    checkOutput({name, "ResValid"}, res_valid, 1'b0);
    checkOutput({name, "ResData"}, res_data, 16'h0000);
    checkOutput({name, "Busy"}, busy, 1'b0);
    checkOutput({name, "PerfOps"}, perf_ops, 0);
    checkOutput({name, "PerfStall"}, perf_stall, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    checkReset("rst0");
    nRST = 1'b1;
    @(posedge clk); #1;

    // Single op: 2.0 * 3.0 + 1.0 = 7.0
    applyStimulus(16'h4000, 16'h4200, 16'h3C00, 1'b1, 1'b1, 16'h3C00, 16'h4700, 1'b1);
    waitDone("single");

    // Chain: 1*2+0 = 2.0 fed back, then 2*2+2 = 6.0; op_acc of B must be ignored
    applyStimulus(16'h3C00, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h4000, 1'b0);
    applyStimulus(16'h4000, 16'h4000, 16'h1234, 1'b0, 1'b1, 16'h4000, 16'h4600, 1'b1);
    waitDone("chain");

    // Backpressure for five OUT cycles
    stallSeen = 0;
    res_ready = 1'b0;
    applyStimulus(16'h3C00, 16'h3C00, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h3C00, 1'b1);
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bpResValid", res_valid, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    res_ready = 1'b1;
    waitDone("backpressure");
    checkOutput("bpStallCycles", stallSeen, 5);
`ifdef MAC_OP_DRIVER_PERF_EN
    checkOutput("perfOps", perf_ops, 4);
    checkOutput("perfStall", perf_stall, 5);
`else
    checkOutput("perfOps", perf_ops, 0);
    checkOutput("perfStall", perf_stall, 0);
`endif

    // Overflow saturation from the MAC passes through untouched
    applyStimulus(16'h7BFF, 16'h4000, 16'h7BFF, 1'b1, 1'b1, 16'h7BFF, 16'h7C00, 1'b1);
    waitDone("overflow");

    // op_first mid-chain discards the 4.0 accumulator in favour of op_acc 1.0
    applyStimulus(16'h4000, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h4400, 1'b0);
    applyStimulus(16'h4000, 16'h4200, 16'h3C00, 1'b1, 1'b1, 16'h3C00, 16'h4700, 1'b1);
    waitDone("restartChain");

    // Reset one cycle after ISSUE of a chained op aborts it
    applyStimulus(16'h3C00, 16'h4000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h4000, 1'b0);
    applyStimulus(16'h4000, 16'h4000, 16'h0000, 1'b0, 1'b1, 16'h4000, 16'h4600, 1'b0);
    @(posedge clk); #1;
    nRST = 1'b0;
    #1;
    checkReset("rstWait");
    @(posedge clk); #1;
    nRST = 1'b1;
    @(posedge clk); #1;
    applyStimulus(16'h3800, 16'h4000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h3C00, 1'b1);
    waitDone("afterReset");
    applyStimulus(16'h3C00, 16'h3C00, 16'h3800, 1'b0, 1'b1, 16'h3800, 16'h3E00, 1'b1);
    waitDone("noChainAfterLast");

    // Operand stability while op inputs toggle with op_valid held high
    applyStimulus(16'h4400, 16'h3C00, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h4400, 1'b1);
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1;
      op_value = 16'hA000 + 16'(i);
      op_weight = 16'hB000 + 16'(i);
      op_acc = 16'hC000 + 16'(i);
      op_first = 1'b1;
      op_last = 1'b1;
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    waitDone("stability");

    checkOutput("macQueueDrained", macQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
